md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  E-stage holds a valid md instruction this cycle.
REQ-006 md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-007 a  in  32  rs operand (forwarded).
REQ-008 b  in  32  rt operand (forwarded).
REQ-009 kill  in  1  exception/interrupt flush this cycle; cancels the E-stage start.
REQ-010 md_use_d  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-011 busy  out  1  multi-cycle operation in progress (registered).
REQ-012 stall  out  1  freeze PC/F/D and bubble E (combinational).
REQ-013 hi  out  32  HI register (registered).
REQ-014 lo  out  32  LO register (registered).

Function
REQ-015 The sequencer SHALL be an FSM with states IDLE, MUL, DIV and a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-016 Accept condition SHALL be start && !kill && state==IDLE; any other start SHALL be ignored with no state change.
REQ-017 On accept with op 1/2 the block SHALL latch a, b, md_op, load counter=MULT_CYCLES and enter MUL; with op 3/4, load DIV_CYCLES and enter DIV.
REQ-018 busy SHALL be 1 for exactly N consecutive cycles beginning the cycle after the accepting edge (N = MULT_CYCLES or DIV_CYCLES), then 0.
REQ-019 The counter SHALL decrement once per cycle in MUL/DIV; on the edge where it goes from 1 to 0 the FSM SHALL return to IDLE and commit hi/lo on that same edge.
REQ-020 mult: {hi,lo} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-021 div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend; divu: unsigned quotient/remainder.
REQ-022 Divisor 0 SHALL take full DIV_CYCLES, assert busy normally, and leave hi/lo unchanged.
REQ-023 Signed div 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 with no exception.
REQ-024 Accepted mthi/mtlo SHALL write a into hi/lo on the next edge, stay in IDLE, not assert busy.
REQ-025 md_op 0 or 7 with start SHALL be a no-op.
REQ-026 hi/lo SHALL hold their previous values for the whole busy window; commit computes only from the operands latched at accept.
REQ-027 stall SHALL equal md_use_d && (busy || (start && (md_op==1..4))); it SHALL not depend on kill.
REQ-028 kill while busy SHALL NOT abort the operation (it belongs to an older, committed instruction); the result still commits on schedule.
REQ-029 The block SHALL be parameter-correct for any MULT_CYCLES, DIV_CYCLES >= 1.

Reset
REQ-030 When reset is high at an edge: state=IDLE, counter=0, busy=0, hi=0, lo=0, latched operands=0.
REQ-031 reset SHALL override a simultaneous start and abort an in-progress MUL/DIV with no hi/lo commit.
REQ-032 stall SHALL be 0 in the cycle after reset when start=0.

Verification
REQ-033 mult a=0xFFFFFFFE, b=3 accepted at edge 0 -> busy=1 edges 1..5, at edge 5 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0 from edge 5.
REQ-034 multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-035 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles; repeat with b=0 -> busy 10 cycles, hi/lo unchanged.
REQ-036 mthi a=0x12345678 -> hi=0x12345678 next edge, busy stays 0; md_use_d=1 during a div busy window -> stall=1 every busy cycle, 0 after completion.
REQ-037 start div with kill=1 -> no busy, hi/lo unchanged; kill pulsed mid-mult -> result still commits at cycle 5.
REQ-038 reset asserted on busy cycle 3 of div -> next cycle busy=0, hi=lo=0, no later commit.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle HI/LO multiply/divide sequencer for the E stage.
// An accepted mult/multu/div/divu holds busy for a fixed cycle count and
// commits HI/LO on the edge where the countdown expires. mthi/mtlo write
// HI/LO in one cycle. stall tells the front end to wait on HI/LO users.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        kill,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_q, b_q;
    logic [2:0]       op_q;

    logic accept, is_mul_op, is_div_op, done;

    assign accept    = start && !kill && (state == IDLE);
    assign is_mul_op = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div_op = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    // Countdown never sits at 0 inside MUL/DIV because both loads are >= 1.
    assign done      = (state != IDLE) && (cnt == CNT_ONE);

    // State register, countdown and operand latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            state <= next_state;
            if (accept && (is_mul_op || is_div_op)) begin
                cnt  <= is_mul_op ? MULT_LD : DIV_LD;
                a_q  <= a;
                b_q  <= b;
                op_q <= md_op;
            end else if (state != IDLE) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // Next-state: leave IDLE only on an accepted arithmetic op; return on expiry.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && is_mul_op)      next_state = MUL;
                else if (accept && is_div_op) next_state = DIV;
            end
            MUL, DIV: begin
                if (done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs: busy comes straight from the state flop; stall ignores kill so
    // the front end is held even while the E-stage op is being flushed.
    always_comb begin
        busy  = (state != IDLE);
        stall = md_use_d && (busy || (start && (is_mul_op || is_div_op)));
    end

    // Result datapath, evaluated only from the latched operands.
    logic [63:0] prod_s, prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        div_ovf;

    always_comb begin
        prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        // INT_MIN / -1 wraps to INT_MIN with remainder 0; handled explicitly.
        div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        quot_s  = '0;
        rem_s   = '0;
        quot_u  = '0;
        rem_u   = '0;
        if (b_q != 32'd0) begin
            quot_u = a_q / b_q;
            rem_u  = a_q % b_q;
            if (div_ovf) begin
                quot_s = 32'h8000_0000;
                rem_s  = 32'd0;
            end else begin
                quot_s = $unsigned($signed(a_q) / $signed(b_q));
                rem_s  = $unsigned($signed(a_q) % $signed(b_q));
            end
        end
    end

    // HI/LO: commit on countdown expiry (divide by zero leaves them alone),
    // or take a directly for accepted mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            case (op_q)
                OP_MULT:  {hi, lo} <= prod_s;
                OP_MULTU: {hi, lo} <= prod_u;
                OP_DIV:   if (b_q != 32'd0) begin hi <= rem_s; lo <= quot_s; end
                OP_DIVU:  if (b_q != 32'd0) begin hi <= rem_u; lo <= quot_u; end
                default: ;
            endcase
        end else if (accept && (md_op == OP_MTHI)) begin
            hi <= a;
        end else if (accept && (md_op == OP_MTLO)) begin
            lo <= a;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed tests for md_sequencer with default cycle counts.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_md_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, kill, md_use_d;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int pass_cnt = 0;
    int total    = 0;
    logic [31:0] exp_hi, exp_lo;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .kill(kill), .md_use_d(md_use_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one start for one edge, then drop it.
    task automatic issue(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb, input logic k);
        md_op = op; a = aa; b = bb; kill = k; start = 1'b1;
        step();
        start = 1'b0; kill = 1'b0; md_op = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; kill = 1'b0; md_use_d = 1'b1; md_op = 3'd0; a = '0; b = '0;
        step(); step();
        reset = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else pass_cnt++;
        total++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else pass_cnt++;
        step();
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else pass_cnt++;
        md_use_d = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_mult();
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        for (int i = 0; i < MC; i++) begin
            total++; if (busy !== 1'b1) $display("FAIL mult_busy cyc %0d got %b want 1", i, busy); else pass_cnt++;
            total++; if (hi !== exp_hi || lo !== exp_lo) $display("FAIL mult_hold cyc %0d got %h_%h want %h_%h", i, hi, lo, exp_hi, exp_lo); else pass_cnt++;
            step();
        end
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA;
        total++; if (busy !== 1'b0) $display("FAIL mult_done_busy got %b want 0", busy); else pass_cnt++;
        total++; if (hi !== exp_hi || lo !== exp_lo) $display("FAIL mult_result got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); else pass_cnt++;
    endtask

    task automatic test_multu();
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        for (int i = 0; i < MC; i++) step();
        exp_hi = 32'h0000_0001; exp_lo = 32'hFFFF_FFFE;
        total++; if (busy !== 1'b0) $display("FAIL multu_busy got %b want 0", busy); else pass_cnt++;
        total++; if (hi !== exp_hi || lo !== exp_lo) $display("FAIL multu_result got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); else pass_cnt++;
    endtask

    task automatic test_div();
        int nbusy;
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        nbusy = 0;
        for (int i = 0; i < DC; i++) begin
            if (busy === 1'b1) nbusy++;
            step();
        end
        total++; if (nbusy != DC) $display("FAIL div_busy_len got %0d want %0d", nbusy, DC); else pass_cnt++;
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
        total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) $display("FAIL div_result got b%b %h_%h want b0 %h_%h", busy, hi, lo, exp_hi, exp_lo); else pass_cnt++;
        // divide by zero: full window, no write
        issue(3'd3, 32'hFFFF_FFF9, 32'd0, 1'b0);
        nbusy = 0;
        for (int i = 0; i < DC; i++) begin
            if (busy === 1'b1) nbusy++;
            step();
        end
        total++; if (nbusy != DC) $display("FAIL div0_busy_len got %0d want %0d", nbusy, DC); else pass_cnt++;
        total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) $display("FAIL div0_hold got b%b %h_%h want b0 %h_%h", busy, hi, lo, exp_hi, exp_lo); else pass_cnt++;
        // INT_MIN / -1
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < DC; i++) step();
        exp_hi = 32'd0; exp_lo = 32'h8000_0000;
        total++; if (hi !== exp_hi || lo !== exp_lo) $display("FAIL div_ovf got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); else pass_cnt++;
        // unsigned 0xFFFFFFF9 / 2 = 0x7FFFFFFC r 1
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        for (int i = 0; i < DC; i++) step();
        exp_hi = 32'd1; exp_lo = 32'h7FFF_FFFC;
        total++; if (hi !== exp_hi || lo !== exp_lo) $display("FAIL divu_result got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); else pass_cnt++;
    endtask

    task automatic test_mthi_mtlo();
        issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
        exp_hi = 32'h1234_5678;
        total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) $display("FAIL mthi got b%b %h_%h want b0 %h_%h", busy, hi, lo, exp_hi, exp_lo); else pass_cnt++;
        issue(3'd6, 32'hAABB_CCDD, 32'd0, 1'b0);
        exp_lo = 32'hAABB_CCDD;
        total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) $display("FAIL mtlo got b%b %h_%h want b0 %h_%h", busy, hi, lo, exp_hi, exp_lo); else pass_cnt++;
    endtask

    task automatic test_noop();
        issue(3'd0, 32'h1111_1111, 32'd5, 1'b0);
        issue(3'd7, 32'h2222_2222, 32'd5, 1'b0);
        total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) $display("FAIL noop got b%b %h_%h want b0 %h_%h", busy, hi, lo, exp_hi, exp_lo); else pass_cnt++;
    endtask

    task automatic test_stall();
        md_use_d = 1'b1;
        md_op = 3'd4; a = 32'd100; b = 32'd7; start = 1'b1; kill = 1'b0;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL stall_start got %b want 1", stall); else pass_cnt++;
        step();
        start = 1'b0; md_op = 3'd0;
        for (int i = 0; i < DC; i++) begin
            total++; if (stall !== 1'b1) $display("FAIL stall_busy cyc %0d got %b want 1", i, stall); else pass_cnt++;
            step();
        end
        exp_hi = 32'd2; exp_lo = 32'd14;
        total++; if (stall !== 1'b0 || busy !== 1'b0) $display("FAIL stall_after got s%b b%b want s0 b0", stall, busy); else pass_cnt++;
        total++; if (hi !== exp_hi || lo !== exp_lo) $display("FAIL stall_divu got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); else pass_cnt++;
        // mthi does not stall; killed mult still stalls
        md_op = 3'd5; start = 1'b1; #1;
        total++; if (stall !== 1'b0) $display("FAIL stall_mthi got %b want 0", stall); else pass_cnt++;
        md_op = 3'd1; kill = 1'b1; #1;
        total++; if (stall !== 1'b1) $display("FAIL stall_kill got %b want 1", stall); else pass_cnt++;
        start = 1'b0; kill = 1'b0; md_op = 3'd0; md_use_d = 1'b0;
        step();
    endtask

    task automatic test_kill();
        issue(3'd3, 32'd100, 32'd7, 1'b1);
        total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) $display("FAIL kill_start got b%b %h_%h want b0 %h_%h", busy, hi, lo, exp_hi, exp_lo); else pass_cnt++;
        issue(3'd1, 32'd7, 32'd6, 1'b0);
        for (int i = 0; i < MC; i++) begin
            kill = (i == 2);
            step();
        end
        kill = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd42;
        total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) $display("FAIL kill_mid got b%b %h_%h want b0 %h_%h", busy, hi, lo, exp_hi, exp_lo); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // second start during busy is ignored
        issue(3'd1, 32'd3, 32'd4, 1'b0);
        issue(3'd3, 32'd100, 32'd7, 1'b0);
        for (int i = 1; i < MC; i++) step();
        exp_hi = 32'd0; exp_lo = 32'd12;
        total++; if (busy !== 1'b0 || lo !== exp_lo || hi !== exp_hi) $display("FAIL b2b_result got b%b %h_%h want b0 %h_%h", busy, hi, lo, exp_hi, exp_lo); else pass_cnt++;
        step();
        total++; if (busy !== 1'b0) $display("FAIL b2b_ignored got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        issue(3'd4, 32'd100, 32'd7, 1'b0);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) $display("FAIL rst_abort got b%b %h_%h want b0 0_0", busy, hi, lo); else pass_cnt++;
        for (int i = 0; i < DC; i++) step();
        total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) $display("FAIL rst_no_commit got b%b %h_%h want b0 0_0", busy, hi, lo); else pass_cnt++;
        // reset beats a simultaneous start
        reset = 1'b1;
        issue(3'd1, 32'd3, 32'd4, 1'b0);
        reset = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL rst_vs_start got %b want 0", busy); else pass_cnt++;
        for (int i = 0; i < MC; i++) step();
        total++; if (lo !== 32'd0) $display("FAIL rst_vs_start_lo got %h want 0", lo); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi_mtlo();
        test_noop();
        test_stall();
        test_kill();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
